phys_reg_free_list: RTL

//  Physical-register free list for the rename stage. Supplies a free physical tag to the ROB on each allocate.

---
 rtl/rename_pkg.sv | 8 +
 rtl/phys_reg_free_list_if.sv | 24 ++
 rtl/free_list_dup_check.sv | 41 ++++
 rtl/phys_reg_free_list.sv | 75 +++++++
 4 files changed

// File: rtl/rename_pkg.sv
// rename_pkg: tag type and sizing shared by the free list, ROB and map table
package rename_pkg;
  localparam int TAG_W = 32;
  localparam int NUM_PREG = 32;
  localparam int NUM_AREG = 4;
  typedef logic [TAG_W-1:0] tag_t;
  localparam tag_t NULL_TAG = '0;
endpackage

// File: rtl/phys_reg_free_list_if.sv
// phys_reg_free_list_if: allocate/return bundle between ROB (master) and free list (slave)
interface phys_reg_free_list_if #(
  parameter int CNT_W = $clog2(rename_pkg::NUM_PREG + 1)
) ();
  import rename_pkg::*;
  logic alloc_req;
  tag_t free_list_PR_out;
  logic free_list_not_empty;
  logic retire_free_valid;
  tag_t retire_free_tag;
  logic squash_free_valid;
  tag_t squash_free_tag;
  logic [CNT_W-1:0] free_count;
  logic overflow_err;
  logic double_free_err;
  modport master (
    output alloc_req, retire_free_valid, retire_free_tag, squash_free_valid, squash_free_tag,
    input free_list_PR_out, free_list_not_empty, free_count, overflow_err, double_free_err
  );
  modport slave (
    input alloc_req, retire_free_valid, retire_free_tag, squash_free_valid, squash_free_tag,
    output free_list_PR_out, free_list_not_empty, free_count, overflow_err, double_free_err
  );
endinterface

// File: rtl/free_list_dup_check.sv
// free_list_dup_check: membership bitmap of free tags, flags frees of tags already held
module free_list_dup_check #(
  parameter int NUM_PREG = rename_pkg::NUM_PREG,
  parameter int NUM_AREG = rename_pkg::NUM_AREG,
  parameter int IW = $clog2(NUM_PREG)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pop_i,
  input  logic [IW-1:0] pop_tag_i,
  input  logic          retire_ok_i,
  input  logic [IW-1:0] retire_tag_i,
  input  logic          squash_ok_i,
  input  logic [IW-1:0] squash_tag_i,
  input  logic          retire_acc_i,
  input  logic          squash_acc_i,
  output logic          retire_dup_o,
  output logic          squash_dup_o,
  output logic          double_free_err_o
);
  logic [NUM_PREG-1:0] in_list_q, in_list_d;
  logic err_q;
  assign retire_dup_o = in_list_q[retire_tag_i];
  // a squash carrying the same tag as a valid retire loses to the retire
  assign squash_dup_o = in_list_q[squash_tag_i] || (retire_ok_i && retire_tag_i == squash_tag_i);
  assign double_free_err_o = err_q;
  always_comb begin
    in_list_d = in_list_q;
    if (pop_i) in_list_d[pop_tag_i] = 1'b0;
    if (retire_acc_i) in_list_d[retire_tag_i] = 1'b1;
    if (squash_acc_i) in_list_d[squash_tag_i] = 1'b1;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      for (int i = 0; i < NUM_PREG; i++) in_list_q[i] <= i > NUM_AREG;
      err_q <= 1'b0;
    end else begin
      in_list_q <= in_list_d;
      err_q <= err_q | (retire_ok_i && retire_dup_o) | (squash_ok_i && squash_dup_o);
    end
endmodule

// File: rtl/phys_reg_free_list.sv
// phys_reg_free_list: circular FIFO of free physical tags; FREE_LIST_DUP_CHECK_EN adds double-free detection
module phys_reg_free_list #(
  parameter int NUM_PREG = rename_pkg::NUM_PREG,
  parameter int NUM_AREG = rename_pkg::NUM_AREG
) (
  input logic clk,
  input logic reset,
  phys_reg_free_list_if.slave fl
);
  import rename_pkg::*;
  localparam int DEPTH = NUM_PREG - 1 - NUM_AREG;
  localparam int PW = $clog2(DEPTH);
  localparam int CNT_W = $clog2(NUM_PREG + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  tag_t mem_q [DEPTH];
  logic [PW-1:0] head_q, tail_q;
  logic [CNT_W-1:0] count_q, count_d, room;
  logic ovf_q, pop, ok_r, ok_s, dup_r, dup_s, cand_r, cand_s, acc_r, acc_s;
  function automatic logic [PW-1:0] adv(input logic [PW-1:0] p, input int n);
    int s;
    s = int'(p) + n;
    return PW'(s >= DEPTH ? s - DEPTH : s);
  endfunction
  assign pop = fl.alloc_req && count_q != '0;
  assign ok_r = fl.retire_free_valid && fl.retire_free_tag != NULL_TAG && fl.retire_free_tag < tag_t'(NUM_PREG);
  assign ok_s = fl.squash_free_valid && fl.squash_free_tag != NULL_TAG && fl.squash_free_tag < tag_t'(NUM_PREG);
  assign cand_r = ok_r && !dup_r;
  assign cand_s = ok_s && !dup_s;
  // a same-cycle pop frees one slot for the incoming tags
  assign room = DEPTH_C - count_q + CNT_W'(pop);
  assign acc_r = cand_r && room != '0;
  assign acc_s = cand_s && room > CNT_W'(acc_r);
  assign count_d = count_q - CNT_W'(pop) + CNT_W'(acc_r) + CNT_W'(acc_s);
  assign fl.free_list_PR_out = mem_q[head_q];
  assign fl.free_list_not_empty = count_q != '0;
  assign fl.free_count = count_q;
  assign fl.overflow_err = ovf_q;
`ifdef FREE_LIST_DUP_CHECK_EN
  localparam int IW = $clog2(NUM_PREG);
  free_list_dup_check #(.NUM_PREG(NUM_PREG), .NUM_AREG(NUM_AREG)) u_dup (
    .clk(clk),
    .reset(reset),
    .pop_i(pop),
    .pop_tag_i(fl.free_list_PR_out[IW-1:0]),
    .retire_ok_i(ok_r),
    .retire_tag_i(fl.retire_free_tag[IW-1:0]),
    .squash_ok_i(ok_s),
    .squash_tag_i(fl.squash_free_tag[IW-1:0]),
    .retire_acc_i(acc_r),
    .squash_acc_i(acc_s),
    .retire_dup_o(dup_r),
    .squash_dup_o(dup_s),
    .double_free_err_o(fl.double_free_err)
  );
`else
  assign dup_r = 1'b0;
  assign dup_s = 1'b0;
  assign fl.double_free_err = 1'b0;
`endif
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= tag_t'(NUM_AREG + 1 + i);
      head_q <= '0;
      tail_q <= '0;
      count_q <= DEPTH_C;
      ovf_q <= 1'b0;
    end else begin
      if (acc_r) mem_q[tail_q] <= fl.retire_free_tag;
      if (acc_s) mem_q[acc_r ? adv(tail_q, 1) : tail_q] <= fl.squash_free_tag;
      head_q <= pop ? adv(head_q, 1) : head_q;
      tail_q <= adv(tail_q, int'(acc_r) + int'(acc_s));
      count_q <= count_d;
      ovf_q <= ovf_q | (cand_r && !acc_r) | (cand_s && !acc_s);
    end
endmodule
